tail_light_sequencer: RTL and testbench
=======================================

# tail_light_sequencer

Controller for the six rear lamps that arbitrates left-turn, right-turn, hazard and brake requests onto one shared 6-bit lamp output. It latches turn requests, serves them in round-robin order, and steps a sequencing state machine at a divided tick rate. It sits between the dashboard switch inputs and the lamp drivers, replacing direct per-switch control of the lamp bank.

## Interface
- TICK_DIV, 25_000_000: clock cycles per sequence step (250 ms at 100 MHz); must be ≥ 2.
- CNT_W, 25: width of the tick counter; must satisfy 2^CNT_W ≥ TICK_DIV.
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- left_req  input  1  left-turn request; level or one-cycle pulse, latched internally.
- right_req  input  1  right-turn request; level or one-cycle pulse, latched internally.
- hazard  input  1  hazard switch, level.
- brake  input  1  brake pedal, level.
- out  output  6  lamp drives. out[5:3] are the left lamps, outer to inner (bit 3 innermost). out[2:0] are the right lamps, inner to outer (bit 2 innermost).
- busy  output  1  high whenever the state is not IDLE (registered).
- side  output  2  current owner of the lamps: 00 none, 01 left, 10 right, 11 hazard (registered).

## Operation
- **Tick counter.**
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - tick is high for exactly the one cycle where count == TICK_DIV-1.
  - The counter runs freely and never stalls.
- **Request latches pend_l and pend_r.**
  - A latch is set on any cycle its request input is high.
  - It is cleared only in the cycle its sequence is launched; a set in that same cycle is lost, because clear wins.
  - Latches persist across hazard.
- **last_served register.**
  - 0 means left was served last; 1 means right was served last.
  - Resets to 1, so the first left/right conflict goes to left.
- **States:** IDLE, L1, L2, L3, LOFF, R1, R2, R3, ROFF, H_ON, H_OFF. The state changes only on tick cycles.
- **Transitions on tick, in priority order:**
  - hazard=1: from any non-hazard state go to H_ON. Any in-progress turn sequence is dropped and not re-queued. In a hazard state, toggle H_ON ↔ H_OFF.
  - hazard=0 in H_ON or H_OFF: go to IDLE.
  - IDLE with only pend_l set: go to L1, clear pend_l, set last_served=0.
  - IDLE with only pend_r set: go to R1, clear pend_r, set last_served=1.
  - IDLE with both set: serve the side opposite last_served. The other latch stays pending.
  - Left sequence: L1→L2→L3→LOFF→IDLE. Right sequence: R1→R2→R3→ROFF→IDLE. A new request is not accepted before returning to IDLE.
- **Lamp decode (base pattern):**
  - IDLE: 000000
  - L1: 001000, L2: 011000, L3: 111000, LOFF: 000000
  - R1: 000100, R2: 000110, R3: 000111, ROFF: 000000
  - H_ON: 111111, H_OFF: 000000
- **Brake overlay (brake=1):**
  - Every side not owned by the active turn sequence is forced to 111.
  - IDLE → 111111. Any L state → right bits 111. Any R state → left bits 111.
  - H_ON and H_OFF → 111111, so brake overrides the hazard off phase.
- **Registered outputs.** out, busy and side are registered each cycle from the present state and brake.
- **Reset.** Reset_n=0 asynchronously forces state=IDLE, counter=0, pend_l=pend_r=0, last_served=1, out=000000, busy=0, side=00.

## Timing
- Output latency: state update at tick edge N, then out/busy/side update at edge N+1. Brake change → out change at the next edge.
- Request to first lamp:
  - A request latched before a tick edge launches at that edge.
  - The lamp is visible one cycle later, so worst case is TICK_DIV+1 cycles.
  - A request arriving in the tick cycle itself is latched and considered at that same edge only if it was already present in pend_* before the edge. Otherwise it waits for the next tick.
- Dwell: each sequence state holds for exactly TICK_DIV cycles. A full turn sequence occupies 4·TICK_DIV cycles.
- Hazard preemption occurs at the first tick with hazard=1. Releasing hazard returns to IDLE at the first tick with hazard=0.
- Reset mid-sequence: outputs clear immediately, with no wait for Clk. Operation resumes with the counter at 0 on the first edge after release.

## Test plan
- TICK_DIV=4, one-cycle left_req pulse in IDLE:
  - Required: out steps 001000, 011000, 111000, 000000, with 4 cycles per step.
  - Required: side=01 throughout; busy drops when the state returns to IDLE.
- left_req and right_req pulsed in the same cycle after reset:
  - Required: the left sequence runs first, then the right sequence launches at the tick after LOFF→IDLE.
  - Repeat the stimulus: right is served first this time.
- Hazard asserted during L2:
  - Required: the next tick goes to H_ON, and out alternates 111111 / 000000 every 4 cycles.
  - Release hazard: return to IDLE, and the left sequence does not resume.
- brake=1 during the R2 state:
  - Required: out=111110 one cycle after brake rises.
  - Required: out=000000 in IDLE with brake=0, and out=111111 in IDLE with brake=1.
- right_req held while hazard is active, then hazard released:
  - Required: the pending right request survives and R1 starts at the tick after the IDLE tick.
- Reset_n pulled low mid-R3, asynchronously between clock edges:
  - Required: out=000000, busy=0, side=00 immediately, and pend_* cleared.

Source files
------------

// File: rtl/tail_light_sequencer.sv
// Rear lamp sequencer: arbitrates latched left/right turn requests, hazard and
// brake onto a shared 6-bit lamp bank, stepping at a divided tick rate.
module tail_light_sequencer #(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned CNT_W    = 25
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard,
  input  logic       brake,
  output logic [5:0] out,
  output logic       busy,
  output logic [1:0] side
);

  localparam int unsigned LAMP_W = 6;
  localparam int unsigned SIDE_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, L1, L2, L3, LOFF, R1, R2, R3, ROFF, H_ON, H_OFF
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               tick_c;
  logic               pend_l, pend_r;
  logic               last_served;
  logic               launch_l_c, launch_r_c;
  logic [LAMP_W-1:0]  out_c;
  logic               busy_c;
  logic [SIDE_W-1:0]  side_c;

  // Free-running step divider
  assign tick_c = (cnt == CNT_MAX);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)    cnt <= '0;
    else if (tick_c) cnt <= '0;
    else             cnt <= cnt + CNT_W'(1);
  end

  // Request latches; a launch clears its latch even if the request is high that cycle
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_l      <= 1'b0;
      pend_r      <= 1'b0;
      last_served <= 1'b1;
    end else begin
      pend_l <= launch_l_c ? 1'b0 : (pend_l | left_req);
      pend_r <= launch_r_c ? 1'b0 : (pend_r | right_req);
      if (launch_l_c)      last_served <= 1'b0;
      else if (launch_r_c) last_served <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state, evaluated only on tick; hazard preempts everything
  always_comb begin
    state_nx   = state;
    launch_l_c = 1'b0;
    launch_r_c = 1'b0;
    if (tick_c) begin
      if (hazard) begin
        state_nx = (state == H_ON) ? H_OFF : H_ON;
      end else begin
        case (state)
          IDLE: begin
            if (pend_l && (!pend_r || last_served)) begin
              state_nx   = L1;
              launch_l_c = 1'b1;
            end else if (pend_r) begin
              state_nx   = R1;
              launch_r_c = 1'b1;
            end
          end
          L1:      state_nx = L2;
          L2:      state_nx = L3;
          L3:      state_nx = LOFF;
          LOFF:    state_nx = IDLE;
          R1:      state_nx = R2;
          R2:      state_nx = R3;
          R3:      state_nx = ROFF;
          ROFF:    state_nx = IDLE;
          H_ON:    state_nx = IDLE;
          H_OFF:   state_nx = IDLE;
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  // Lamp decode with brake forcing every side not owned by a turn sequence on
  always_comb begin
    out_c  = '0;
    busy_c = (state != IDLE);
    side_c = 2'b00;
    case (state)
      L1:      begin out_c = 6'b001000; side_c = 2'b01; end
      L2:      begin out_c = 6'b011000; side_c = 2'b01; end
      L3:      begin out_c = 6'b111000; side_c = 2'b01; end
      LOFF:    begin out_c = 6'b000000; side_c = 2'b01; end
      R1:      begin out_c = 6'b000100; side_c = 2'b10; end
      R2:      begin out_c = 6'b000110; side_c = 2'b10; end
      R3:      begin out_c = 6'b000111; side_c = 2'b10; end
      ROFF:    begin out_c = 6'b000000; side_c = 2'b10; end
      H_ON:    begin out_c = 6'b111111; side_c = 2'b11; end
      H_OFF:   begin out_c = 6'b000000; side_c = 2'b11; end
      default: begin out_c = 6'b000000; side_c = 2'b00; end
    endcase
    if (brake) begin
      case (state)
        L1, L2, L3, LOFF: out_c[2:0] = 3'b111;
        R1, R2, R3, ROFF: out_c[5:3] = 3'b111;
        default:          out_c      = 6'b111111;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out  <= '0;
      busy <= 1'b0;
      side <= '0;
    end else begin
      out  <= out_c;
      busy <= busy_c;
      side <= side_c;
    end
  end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Scoreboard bench for tail_light_sequencer at TICK_DIV=4: expected per-cycle
// {out,busy,side} is queued up front and popped one entry per clock edge.
`timescale 1ns/1ps
module tb_tail_light_sequencer;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned CNT_W    = 3;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       left_req = 1'b0;
  logic       right_req = 1'b0;
  logic       hazard = 1'b0;
  logic       brake = 1'b0;
  logic [5:0] out;
  logic       busy;
  logic [1:0] side;

  logic [8:0] exp_q[$];
  logic [8:0] exp_e;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  string      tname = "";

  tail_light_sequencer #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .left_req(left_req), .right_req(right_req),
    .hazard(hazard), .brake(brake), .out(out), .busy(busy), .side(side)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic push(input int n, input logic [5:0] o, input logic b, input logic [1:0] s);
    repeat (n) exp_q.push_back({o, b, s});
  endtask

  task automatic push_left();
    push(4, 6'b001000, 1'b1, 2'b01);
    push(4, 6'b011000, 1'b1, 2'b01);
    push(4, 6'b111000, 1'b1, 2'b01);
    push(4, 6'b000000, 1'b1, 2'b01);
  endtask

  task automatic push_right();
    push(4, 6'b000100, 1'b1, 2'b10);
    push(4, 6'b000110, 1'b1, 2'b10);
    push(4, 6'b000111, 1'b1, 2'b10);
    push(4, 6'b000000, 1'b1, 2'b10);
  endtask

  // Advance one edge at a time and retire one scoreboard entry per edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        tests++;
        if ({out, busy, side} !== exp_e) begin
          fails++;
          $display("FAIL %s cyc %0d out_busy_side got %b_%b_%b want %b_%b_%b",
                   tname, cyc, out, busy, side, exp_e[8:3], exp_e[2], exp_e[1:0]);
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #4;
    Reset_n = 1'b0;
    left_req = 1'b0; right_req = 1'b0; hazard = 1'b0; brake = 1'b0;
    #1;
    tests++;
    if ({out, busy, side} !== 9'b0) begin
      fails++;
      $display("FAIL %s async_reset got %b_%b_%b want 000000_0_00", tname, out, busy, side);
    end
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    tname = "reset";
    do_reset();
    push(8, 6'b000000, 1'b0, 2'b00);
    step(8);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL %s queue_left got %0d want 0", tname, exp_q.size()); end
  endtask

  task automatic test_left_pulse();
    tname = "left_pulse";
    do_reset();
    push(4, 6'b000000, 1'b0, 2'b00);
    push_left();
    push(2, 6'b000000, 1'b0, 2'b00);
    left_req = 1'b1; step(1); left_req = 1'b0;
    step(21);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL %s queue_left got %0d want 0", tname, exp_q.size()); end
  endtask

  task automatic test_round_robin();
    tname = "round_robin";
    do_reset();
    push(4, 6'b000000, 1'b0, 2'b00);
    push_left();
    push(4, 6'b000000, 1'b0, 2'b00);
    push_right();
    push(4, 6'b000000, 1'b0, 2'b00);
    push_left();
    push(4, 6'b000000, 1'b0, 2'b00);
    left_req = 1'b1; right_req = 1'b1; step(1);
    left_req = 1'b0; right_req = 1'b0; step(8);
    left_req = 1'b1; right_req = 1'b1; step(1);
    left_req = 1'b0; right_req = 1'b0; step(54);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL %s queue_left got %0d want 0", tname, exp_q.size()); end
  endtask

  task automatic test_hazard_preempt();
    tname = "hazard_preempt";
    do_reset();
    push(4, 6'b000000, 1'b0, 2'b00);
    push(4, 6'b001000, 1'b1, 2'b01);
    push(4, 6'b011000, 1'b1, 2'b01);
    push(4, 6'b111111, 1'b1, 2'b11);
    push(4, 6'b000000, 1'b1, 2'b11);
    push(4, 6'b111111, 1'b1, 2'b11);
    push(4, 6'b000000, 1'b1, 2'b11);
    push(8, 6'b000000, 1'b0, 2'b00);
    left_req = 1'b1; step(1); left_req = 1'b0;
    step(8);
    hazard = 1'b1; step(16);
    hazard = 1'b0; step(11);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL %s queue_left got %0d want 0", tname, exp_q.size()); end
  endtask

  task automatic test_brake();
    tname = "brake";
    do_reset();
    push(4, 6'b000000, 1'b0, 2'b00);
    push(4, 6'b000100, 1'b1, 2'b10);
    push(1, 6'b000110, 1'b1, 2'b10);
    push(3, 6'b111110, 1'b1, 2'b10);
    push(2, 6'b111111, 1'b1, 2'b10);
    push(2, 6'b000111, 1'b1, 2'b10);
    push(4, 6'b000000, 1'b1, 2'b10);
    push(2, 6'b000000, 1'b0, 2'b00);
    push(2, 6'b111111, 1'b0, 2'b00);
    push(2, 6'b000000, 1'b0, 2'b00);
    right_req = 1'b1; step(1); right_req = 1'b0;
    step(8);
    brake = 1'b1; step(5);
    brake = 1'b0; step(8);
    brake = 1'b1; step(2);
    brake = 1'b0; step(2);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL %s queue_left got %0d want 0", tname, exp_q.size()); end
  endtask

  task automatic test_pending_through_hazard();
    tname = "pending_through_hazard";
    do_reset();
    push(4, 6'b000000, 1'b0, 2'b00);
    push(4, 6'b111111, 1'b1, 2'b11);
    push(4, 6'b000000, 1'b1, 2'b11);
    push(4, 6'b111111, 1'b1, 2'b11);
    push(4, 6'b000000, 1'b0, 2'b00);
    push(4, 6'b000100, 1'b1, 2'b10);
    push(1, 6'b000110, 1'b1, 2'b10);
    hazard = 1'b1; step(1);
    right_req = 1'b1; step(9);
    right_req = 1'b0; step(3);
    hazard = 1'b0; step(12);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL %s queue_left got %0d want 0", tname, exp_q.size()); end
  endtask

  task automatic test_reset_mid_r3();
    tname = "reset_mid_r3";
    do_reset();
    push(4, 6'b000000, 1'b0, 2'b00);
    push(4, 6'b000100, 1'b1, 2'b10);
    push(4, 6'b000110, 1'b1, 2'b10);
    push(2, 6'b000111, 1'b1, 2'b10);
    right_req = 1'b1; step(1); right_req = 1'b0;
    step(4);
    left_req = 1'b1; step(1); left_req = 1'b0;
    step(8);
    #3;
    Reset_n = 1'b0;
    #1;
    tests++;
    if ({out, busy, side} !== 9'b0) begin
      fails++;
      $display("FAIL %s async_clear got %b_%b_%b want 000000_0_00", tname, out, busy, side);
    end
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    cyc = 0;
    push(12, 6'b000000, 1'b0, 2'b00);
    step(12);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL %s queue_left got %0d want 0", tname, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_left_pulse();
    test_round_robin();
    test_hazard_preempt();
    test_brake();
    test_pending_through_hazard();
    test_reset_mid_r3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
